// File: rtl/mma_kloop_sequencer.sv
// Runs one accumulated GEMM tile job on the shared MMA engine: streams K sub-tiles,
// feeds each partial D back as the next C, then hands the final D downstream once.
module mma_kloop_sequencer #(
  parameter int M    = 8,
  parameter int N    = 4,
  parameter int K    = 16,
  parameter int P    = 8,
  parameter int KT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [KT_W-1:0]      cmd_ktiles_i,
  input  logic                 cmd_bias_en_i,
  input  logic                 cmd_halved_i,
  input  logic [4*P*M*N-1:0]   bias_i,
  input  logic                 tile_valid_i,
  output logic                 tile_ready_o,
  input  logic [P*M*K-1:0]     tile_a_i,
  input  logic [P*K*N-1:0]     tile_b_i,
  output logic                 mma_valid_o,
  input  logic                 mma_ready_i,
  output logic [P*M*K-1:0]     mma_a_o,
  output logic [P*K*N-1:0]     mma_b_o,
  output logic [4*P*M*N-1:0]   mma_c_o,
  output logic                 mma_halved_o,
  input  logic                 mma_valid_i,
  output logic                 mma_ready_o,
  input  logic [4*P*M*N-1:0]   mma_d_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [4*P*M*N-1:0]   res_d_o,
  output logic                 busy_o
);

  localparam int CW = 4*P*M*N;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   acc_r;
  logic [KT_W-1:0] remaining_r;
  logic            halved_r;
  logic            in_issue_s;

  assign in_issue_s = (state_r == ST_ISSUE);

  // Job sequencing: command latch, one outstanding MMA op at a time, final handoff.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      acc_r       <= {CW{1'b0}};
      remaining_r <= {KT_W{1'b0}};
      halved_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            acc_r       <= cmd_bias_en_i ? bias_i : {CW{1'b0}};
            remaining_r <= cmd_ktiles_i;
            halved_r    <= cmd_halved_i;
            // A zero-tile job returns the initial accumulator without touching the MMA.
            state_r     <= (cmd_ktiles_i != {KT_W{1'b0}}) ? ST_ISSUE : ST_OUTPUT;
          end
        end
        ST_ISSUE: begin
          if (tile_valid_i && mma_ready_i) begin
            remaining_r <= remaining_r - KT_W'(1);
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mma_valid_i) begin
            acc_r   <= mma_d_i;
            state_r <= (remaining_r == {KT_W{1'b0}}) ? ST_OUTPUT : ST_ISSUE;
          end
        end
        ST_OUTPUT: begin
          if (res_ready_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o  = (state_r == ST_IDLE);
  assign busy_o       = (state_r != ST_IDLE);
  assign mma_valid_o  = in_issue_s & tile_valid_i;
  assign tile_ready_o = in_issue_s & mma_ready_i;
  assign mma_a_o      = tile_a_i;
  assign mma_b_o      = tile_b_i;
  assign mma_c_o      = acc_r;
  assign mma_halved_o = halved_r;
  assign mma_ready_o  = (state_r == ST_WAIT);
  assign res_valid_o  = (state_r == ST_OUTPUT);
  assign res_d_o      = acc_r;

endmodule

// File: tb/tb_mma_kloop_sequencer.sv
// Directed bench for mma_kloop_sequencer: job-level model (counts of issued/completed
// tiles, software matrix sums) checked against the DUT on every cycle.
`timescale 1ns/1ps
module tb_mma_kloop_sequencer;
  localparam int M = 2, N = 2, K = 2, P = 8, KT_W = 8;
  localparam int AW = P*M*K, BW = P*K*N, CW = 4*P*M*N, EW = 4*P;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic cmd_valid_i, cmd_ready_o, cmd_bias_en_i, cmd_halved_i;
  logic [KT_W-1:0] cmd_ktiles_i;
  logic [CW-1:0] bias_i, mma_c_o, mma_d_i, res_d_o;
  logic tile_valid_i, tile_ready_o, mma_valid_o, mma_ready_i, mma_halved_o;
  logic [AW-1:0] tile_a_i, mma_a_o;
  logic [BW-1:0] tile_b_i, mma_b_o;
  logic mma_valid_i, mma_ready_o, res_valid_o, res_ready_i, busy_o;

  always #5 clk_i = ~clk_i;

  mma_kloop_sequencer #(.M(M), .N(N), .K(K), .P(P), .KT_W(KT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_ktiles_i(cmd_ktiles_i),
    .cmd_bias_en_i(cmd_bias_en_i), .cmd_halved_i(cmd_halved_i), .bias_i(bias_i),
    .tile_valid_i(tile_valid_i), .tile_ready_o(tile_ready_o),
    .tile_a_i(tile_a_i), .tile_b_i(tile_b_i),
    .mma_valid_o(mma_valid_o), .mma_ready_i(mma_ready_i),
    .mma_a_o(mma_a_o), .mma_b_o(mma_b_o), .mma_c_o(mma_c_o), .mma_halved_o(mma_halved_o),
    .mma_valid_i(mma_valid_i), .mma_ready_o(mma_ready_o), .mma_d_i(mma_d_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_d_o(res_d_o),
    .busy_o(busy_o)
  );

  int vectors = 0, miscompares = 0, cyc = 0;

  // Job description and model state
  logic [AW-1:0] ja [0:255];
  logic [BW-1:0] jb [0:255];
  int            job_kt = 0;
  logic          job_bias_en = 1'b0, job_halved = 1'b0;
  logic [CW-1:0] job_bias = '0, exp_final = '0, model_acc = '0, last_res = '0;
  bit            exp_busy = 0, cmd_pending = 0;
  int            issued = 0, completed = 0, tile_idx = 0, mma_ops = 0, jobs_done = 0;
  int            cmd_cyc = 0, first_res_cyc = -1;
  int            stall_pct = 0, resp_fixed_lat = -1;

  // MMA engine stand-in
  bit            resp_pending = 0;
  int            resp_lat = 0;
  logic [CW-1:0] resp_d = '0;

  bit            f_cmd, f_issue, f_result, f_res;
  logic [CW-1:0] cap_c, cap_res;
  logic [AW-1:0] cap_a;
  logic [BW-1:0] cap_b;

  // D = C + A*B on unsigned elements, row-major packing, element 0 at the LSBs.
  function automatic logic [CW-1:0] mat_mac(input logic [CW-1:0] c, input logic [AW-1:0] a,
                                            input logic [BW-1:0] b);
    logic [CW-1:0] d;
    logic [EW-1:0] s;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = c[(i*N+j)*EW +: EW];
        for (int k = 0; k < K; k++)
          s = s + EW'(a[(i*K+k)*P +: P]) * EW'(b[(k*N+j)*P +: P]);
        d[(i*N+j)*EW +: EW] = s;
      end
    return d;
  endfunction

  function automatic bit roll_stall();
    return (stall_pct > 0) && ($urandom_range(99) < stall_pct);
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    cmd_valid_i  = cmd_pending;
    if (!cmd_pending) bias_i = {$urandom, $urandom, $urandom, $urandom};
    tile_valid_i = exp_busy && (tile_idx < job_kt) && !roll_stall();
    tile_a_i     = ja[tile_idx];
    tile_b_i     = jb[tile_idx];
    mma_ready_i  = !roll_stall();
    mma_valid_i  = resp_pending && (resp_lat == 0);
    mma_d_i      = resp_d;
    res_ready_i  = !roll_stall();
  endtask

  // Compare DUT outputs with the job-level model for the current cycle.
  task automatic check();
    bit in_wait, in_issue, in_output;
    in_wait   = exp_busy && (issued != completed);
    in_issue  = exp_busy && !in_wait && (issued < job_kt);
    in_output = exp_busy && !in_wait && (issued == job_kt);
    chk_bit("busy", busy_o, exp_busy);
    chk_bit("cmd_ready", cmd_ready_o, !exp_busy);
    chk_bit("mma_valid", mma_valid_o, in_issue && tile_valid_i);
    chk_bit("tile_ready", tile_ready_o, in_issue && mma_ready_i);
    chk_bit("mma_ready", mma_ready_o, in_wait);
    chk_bit("res_valid", res_valid_o, in_output);
    if (in_issue) begin
      chk_vec("mma_a", CW'(mma_a_o), CW'(tile_a_i));
      chk_vec("mma_b", CW'(mma_b_o), CW'(tile_b_i));
      chk_vec("mma_c", mma_c_o, model_acc);
    end
    if (exp_busy) chk_bit("mma_halved", mma_halved_o, job_halved);
    if (in_output) chk_vec("res_d", res_d_o, exp_final);
    if (in_output && first_res_cyc < 0) first_res_cyc = cyc;
    f_cmd    = cmd_valid_i && !exp_busy;
    f_issue  = in_issue && tile_valid_i && mma_ready_i;
    f_result = in_wait && mma_valid_i;
    f_res    = in_output && res_ready_i;
    cap_a = mma_a_o; cap_b = mma_b_o; cap_c = mma_c_o; cap_res = res_d_o;
  endtask

  task automatic commit();
    if (f_cmd) begin
      exp_busy = 1; cmd_pending = 0; issued = 0; completed = 0; tile_idx = 0; mma_ops = 0;
      model_acc = job_bias_en ? job_bias : '0;
      cmd_cyc = cyc; first_res_cyc = -1;
    end
    if (f_issue) begin
      resp_d       = mat_mac(cap_c, cap_a, cap_b);
      resp_pending = 1;
      resp_lat     = (resp_fixed_lat >= 0) ? resp_fixed_lat :
                     ((stall_pct > 0) ? int'($urandom_range(3)) : 0);
      model_acc    = mat_mac(model_acc, ja[tile_idx], jb[tile_idx]);
      issued++; tile_idx++; mma_ops++;
    end else if (resp_pending && resp_lat > 0) begin
      resp_lat--;
    end
    if (f_result) begin
      resp_pending = 0; completed++;
    end
    if (f_res) begin
      exp_busy = 0; last_res = cap_res; jobs_done++;
    end
  endtask

  // One clock: drive at the falling edge, compare 1 ns later, account at the rising edge.
  task automatic cycle();
    drive();
    #1;
    check();
    @(posedge clk_i);
    commit();
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic start_job(input int kt, input logic ben, input logic [CW-1:0] bias,
                           input logic halved);
    job_kt = kt; job_bias_en = ben; job_bias = bias; job_halved = halved;
    exp_final = ben ? bias : '0;
    for (int t = 0; t < kt; t++) exp_final = mat_mac(exp_final, ja[t], jb[t]);
    cmd_ktiles_i = KT_W'(kt); cmd_bias_en_i = ben; cmd_halved_i = halved; bias_i = bias;
    cmd_pending = 1;
  endtask

  task automatic run_job(input int kt, input logic ben, input logic [CW-1:0] bias,
                         input logic halved, input int budget);
    int start, n;
    start_job(kt, ben, bias, halved);
    start = jobs_done;
    n = 0;
    while (jobs_done == start && n < budget) begin
      cycle();
      n++;
    end
    if (jobs_done == start) begin
      vectors++; miscompares++;
      $display("FAIL job_timeout: job of %0d tiles not finished after %0d cycles", kt, budget);
    end
    chk_vec("mma_op_count", CW'(mma_ops), CW'(kt));
  endtask

  task automatic fill_tiles(input int kt, input logic [P-1:0] av, input logic [P-1:0] bv);
    for (int t = 0; t < 256; t++) begin
      ja[t] = (t < kt) ? {(M*K){av}} : '0;
      jb[t] = (t < kt) ? {(K*N){bv}} : '0;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    cmd_valid_i = 0; cmd_ktiles_i = '0; cmd_bias_en_i = 0; cmd_halved_i = 0; bias_i = '0;
    tile_valid_i = 0; tile_a_i = '0; tile_b_i = '0; mma_ready_i = 0; mma_valid_i = 0;
    mma_d_i = '0; res_ready_i = 0;
    fill_tiles(0, 8'd0, 8'd0);
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) cycle();
    chk_vec("reset_acc", mma_c_o, '0);
    chk_bit("reset_halved", mma_halved_o, 1'b0);
    rst_ni = 1'b1;
    cycle();

    // Three tiles of ones*twos on a bias of 10: each element 10 + 3*4 = 22
    fill_tiles(3, 8'd1, 8'd2);
    run_job(3, 1'b1, {(M*N){32'd10}}, 1'b0, 200);
    chk_vec("t1_result", last_res, {4{32'd22}});
    chk_vec("t1_model", exp_final, {4{32'd22}});

    // Zero tiles: bias returned one cycle after the command, MMA untouched
    fill_tiles(0, 8'd0, 8'd0);
    run_job(0, 1'b1, {(M*N){32'd7}}, 1'b0, 50);
    chk_vec("t2_result", last_res, {4{32'd7}});
    chk_vec("t2_latency", CW'(first_res_cyc - cmd_cyc), CW'(1));

    // Two distinct tiles under random stalls everywhere: 19+2, 22+2, 43+7, 50+1
    fill_tiles(0, 8'd0, 8'd0);
    ja[0] = {8'd4, 8'd3, 8'd2, 8'd1}; jb[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    ja[1] = {8'd3, 8'd1, 8'd0, 8'd2}; jb[1] = {8'd0, 8'd2, 8'd1, 8'd1};
    stall_pct = 40;
    run_job(2, 1'b0, {(M*N){32'd99}}, 1'b0, 400);
    chk_vec("t3_result", last_res, {32'd51, 32'd50, 32'd24, 32'd21});
    run_job(2, 1'b0, {(M*N){32'd99}}, 1'b0, 400);
    chk_vec("t3_repeat", last_res, {32'd51, 32'd50, 32'd24, 32'd21});
    stall_pct = 0;

    // Back-to-back jobs with opposite precision modes
    fill_tiles(2, 8'd3, 8'd1);
    run_job(2, 1'b0, '0, 1'b1, 200);
    chk_vec("t4_job1", last_res, {4{32'd12}});
    fill_tiles(1, 8'd2, 8'd2);
    run_job(1, 1'b1, {(M*N){32'd1}}, 1'b0, 200);
    chk_vec("t4_job2", last_res, {4{32'd9}});

    // Reset while waiting on the second MMA result of a four-tile job
    fill_tiles(4, 8'd1, 8'd1);
    resp_fixed_lat = 8;
    start_job(4, 1'b0, '0, 1'b1);
    for (int n = 0; n < 100 && !(issued == 2 && completed == 1); n++) cycle();
    chk_bit("t5_in_wait", mma_ready_o, 1'b1);
    #3 rst_ni = 1'b0;
    #1;
    chk_bit("t5_rst_busy", busy_o, 1'b0);
    chk_bit("t5_rst_cmd_ready", cmd_ready_o, 1'b1);
    chk_bit("t5_rst_mma_ready", mma_ready_o, 1'b0);
    chk_bit("t5_rst_halved", mma_halved_o, 1'b0);
    chk_bit("t5_rst_res_valid", res_valid_o, 1'b0);
    chk_vec("t5_rst_acc", mma_c_o, '0);
    exp_busy = 0; cmd_pending = 0; issued = 0; completed = 0; tile_idx = 0; job_kt = 0;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) cycle();
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    resp_pending = 0; resp_fixed_lat = -1;
    fill_tiles(1, 8'd1, 8'd3);
    run_job(1, 1'b0, '0, 1'b0, 100);
    chk_vec("t5_fresh_job", last_res, {4{32'd6}});

    // Maximum tile count with zero operands: bias passes through 255 MMA ops
    fill_tiles(255, 8'd0, 8'd0);
    run_job(255, 1'b1, {(M*N){32'd5}}, 1'b0, 2000);
    chk_vec("t6_result", last_res, {4{32'd5}});
    chk_vec("t6_ops", CW'(mma_ops), CW'(255));

    for (int i = 0; i < 3; i++) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
